// File: rtl/mem_stage_pkg.sv
// Shared bus layouts, widths and load-op encodings for the memory stage.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 74;
  localparam int unsigned MS_TO_WS_BUS_WD = 70;
  localparam int unsigned MS_TO_DS_BUS_WD = 38;
  localparam int unsigned LD_OP_WD        = 3;

  localparam logic [LD_OP_WD-1:0] LD_OP_W  = 3'd0;
  localparam logic [LD_OP_WD-1:0] LD_OP_B  = 3'd1;
  localparam logic [LD_OP_WD-1:0] LD_OP_BU = 3'd2;
  localparam logic [LD_OP_WD-1:0] LD_OP_H  = 3'd3;
  localparam logic [LD_OP_WD-1:0] LD_OP_HU = 3'd4;

  typedef struct packed {
    logic                res_from_mem;
    logic [LD_OP_WD-1:0] ld_op;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         alu_result;
    logic [31:0]         pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        ld_pending;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_result;
  } ms_to_ds_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data extraction with sign/zero extension.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]         rdata,
  input  logic [1:0]          addr,
  input  logic [LD_OP_WD-1:0] ld_op,
  output logic [31:0]         result
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign shifted  = rdata >> {addr, 3'b000};
  assign byte_val = shifted[7:0];
  assign half_val = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (ld_op)
      LD_OP_B:  result = {{24{byte_val[7]}}, byte_val};
      LD_OP_BU: result = {24'd0, byte_val};
      LD_OP_H:  result = {{16{half_val[15]}}, half_val};
      LD_OP_HU: result = {16'd0, half_val};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for load data, aligns it and hands results
// to write-back while driving the forwarding/load-use bus to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

  es_to_ms_t   es_r;
  ms_to_ws_t   ws_out;
  ms_to_ds_t   ds_out;
  logic        ms_valid;
  logic        buf_valid;
  logic [31:0] rdata_buf;
  logic        ms_ready_go;
  logic        capture;
  logic        leave;
  logic        buf_load;
  logic [31:0] load_src;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign ms_ready_go    = !es_r.res_from_mem || data_sram_data_ok || buf_valid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign capture        = es_to_ms_valid && ms_allowin;
  assign leave          = ms_to_ws_valid && ws_allowin;
  // Only park the response when write-back cannot take it this cycle.
  assign buf_load       = data_sram_data_ok && ms_valid && es_r.res_from_mem
                          && !buf_valid && !ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      es_r <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
    end else if (capture || leave) begin
      buf_valid <= 1'b0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_load) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign load_src = buf_valid ? rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .rdata  (load_src),
    .addr   (es_r.alu_result[1:0]),
    .ld_op  (es_r.ld_op),
    .result (load_result)
  );

  assign final_result = es_r.res_from_mem ? load_result : es_r.alu_result;

  always_comb begin
    ws_out              = '0;
    ws_out.gr_we        = es_r.gr_we;
    ws_out.dest         = es_r.dest;
    ws_out.final_result = final_result;
    ws_out.pc           = es_r.pc;
  end

  // Gated by ms_valid so decode never sees stale or unreset data.
  always_comb begin
    ds_out            = '0;
    ds_out.ld_pending = ms_valid && es_r.res_from_mem && !ms_ready_go;
    ds_out.fwd_dest   = (ms_valid && es_r.gr_we) ? es_r.dest : 5'd0;
    ds_out.fwd_result = ms_valid ? final_result : 32'd0;
  end

  assign ms_to_ws_bus = ws_out;
  assign ms_to_ds_bus = ds_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [37:0] ms_to_ds_bus;

  int n_checks;
  int n_fail;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_bus      (ms_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic res, input logic [2:0] op, input logic we,
                       input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = {res, op, we, dst, alu, pc};
  endtask

  // Capture one load, wait two cycles, then deliver data_ok and check the result.
  task automatic run_load(input string name, input logic [2:0] op, input logic [31:0] alu,
                          input logic [31:0] rdata, input logic [31:0] expv);
    ws_allowin = 1'b1;
    offer(1'b1, op, 1'b1, 5'd9, alu, 32'h1C00_0040);
    tick();
    es_to_ms_valid = 1'b0;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    n_checks++;
    if (ms_to_ws_bus[63:32] !== expv || ms_to_ws_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: valid=%0b result=%h, required valid=1 result=%h",
               name, ms_to_ws_valid, ms_to_ws_bus[63:32], expv);
    end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: allowin=%0b ws_valid=%0b, required 1/0",
               ms_allowin, ms_to_ws_valid);
    end
    n_checks++;
    if (ms_to_ds_bus !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_ds_bus: got %h, required 0", ms_to_ds_bus);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_non_load();
    ws_allowin = 1'b1;
    offer(1'b0, 3'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000}) begin
      n_fail++;
      $display("FAIL nonload_ws: valid=%0b bus=%h, required 1 %h", ms_to_ws_valid, ms_to_ws_bus,
               {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000});
    end
    n_checks++;
    if (ms_to_ds_bus !== {1'b0, 5'd5, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL nonload_ds: got %h, required %h", ms_to_ds_bus, {1'b0, 5'd5, 32'h1234_5678});
    end
    tick();
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nonload_drain: ws_valid=%0b, required 0", ms_to_ws_valid);
    end
  endtask

  task automatic test_lb_sign();
    ws_allowin = 1'b1;
    offer(1'b1, 3'd1, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0010);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (ms_to_ds_bus[37] !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin
        n_fail++;
        $display("FAIL lb_wait%0d: pending=%0b ws_valid=%0b allowin=%0b, required 1/0/0",
                 i, ms_to_ds_bus[37], ms_to_ws_valid, ms_allowin);
      end
      if (i == 0) tick();
    end
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    #1;
    n_checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hFFFF_FF80 || ms_to_ds_bus[37] !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_result: valid=%0b result=%h pending=%0b, required 1 ffffff80 0",
               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ds_bus[37]);
    end
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_drain: ws_valid=%0b, required 0", ms_to_ws_valid);
    end
  endtask

  task automatic test_load_ops();
    run_load("lhu_hi", 3'd4, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF);
    run_load("lw",     3'd0, 32'h0000_2000, 32'hBEEF_1234, 32'hBEEF_1234);
    run_load("lh_lo",  3'd3, 32'h0000_2000, 32'h0000_8001, 32'hFFFF_8001);
    run_load("lbu_b1", 3'd2, 32'h0000_2001, 32'h0000_9A00, 32'h0000_009A);
    run_load("lb_pos", 3'd1, 32'h0000_2000, 32'hFFFF_FF7F, 32'h0000_007F);
    run_load("op6_lw", 3'd6, 32'h0000_2001, 32'h1357_9BDF, 32'h1357_9BDF);
  endtask

  task automatic test_backpressure();
    ws_allowin = 1'b0;
    offer(1'b1, 3'd0, 1'b1, 5'd3, 32'h0000_3000, 32'h1C00_0080);
    tick();
    es_to_ms_valid = 1'b0;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_BABE;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (dut.buf_valid !== 1'b1 || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1
          || ms_to_ws_bus[63:32] !== 32'hCAFE_BABE) begin
        n_fail++;
        $display("FAIL bp_hold%0d: buf=%0b allowin=%0b valid=%0b result=%h, required 1/0/1 cafebabe",
                 i, dut.buf_valid, ms_allowin, ms_to_ws_valid, ms_to_ws_bus[63:32]);
      end
      if (i == 0) tick();
    end
    // Release and capture a new non-load in the same cycle.
    ws_allowin = 1'b1;
    offer(1'b0, 3'd0, 1'b0, 5'd4, 32'h0000_0055, 32'h1C00_0200);
    #1;
    n_checks++;
    if (ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: allowin=%0b, required 1", ms_allowin);
    end
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    n_checks++;
    if (dut.buf_valid !== 1'b0 || ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[31:0] !== 32'h1C00_0200
        || ms_to_ws_bus[63:32] !== 32'h0000_0055) begin
      n_fail++;
      $display("FAIL bp_handoff: buf=%0b valid=%0b pc=%h result=%h, required 0/1 1c000200 00000055",
               dut.buf_valid, ms_to_ws_valid, ms_to_ws_bus[31:0], ms_to_ws_bus[63:32]);
    end
    n_checks++;
    if (ms_to_ds_bus[36:32] !== 5'd0) begin
      n_fail++;
      $display("FAIL bp_no_we_fwd: fwd_dest=%0d, required 0", ms_to_ds_bus[36:32]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    pcs[0] = 32'h1C00_0100;
    pcs[1] = 32'h1C00_0104;
    pcs[2] = 32'h1C00_0108;
    pcs[3] = 32'h1C00_010C;
    ws_allowin = 1'b1;
    offer(1'b0, 3'd0, 1'b1, 5'd1, 32'd100, pcs[0]);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) offer(1'b0, 3'd0, 1'b1, 5'(i + 2), 32'(101 + i), pcs[i+1]);
      else es_to_ms_valid = 1'b0;
      #1;
      n_checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[31:0] !== pcs[i]
          || ms_to_ws_bus[63:32] !== 32'(100 + i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: valid=%0b pc=%h result=%0d, required 1 %h %0d",
                 i, ms_to_ws_valid, ms_to_ws_bus[31:0], ms_to_ws_bus[63:32], pcs[i], 100 + i);
      end
    end
    tick();
    n_checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%0b, required 0", ms_to_ws_valid);
    end
  endtask

  task automatic test_reset_mid_load();
    ws_allowin = 1'b1;
    offer(1'b1, 3'd0, 1'b1, 5'd12, 32'h0000_4000, 32'h1C00_0300);
    tick();
    es_to_ms_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7777_7777;
    #1;
    n_checks++;
    if (ms_to_ds_bus !== 38'd0 || ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_load: ds=%h valid=%0b allowin=%0b, required 0/0/1",
               ms_to_ds_bus, ms_to_ws_valid, ms_allowin);
    end
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if (ms_to_ws_valid !== 1'b0 || dut.buf_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray_ok: valid=%0b buf=%0b, required 0/0", ms_to_ws_valid, dut.buf_valid);
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b1;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    test_reset();
    test_non_load();
    test_lb_sign();
    test_load_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
